// File: rtl/pmod_loopback_tester.sv
// Self-test sequencer for a PMOD port with a loopback jumper (pin i <-> pin i+WIDTH/2).
// Drives walking-one/walking-zero patterns from each half in turn and accumulates mismatches.
module pmod_loopback_tester #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_mask,
  output logic [WIDTH-1:0] pmod_out,
  output logic [WIDTH-1:0] pmod_oe,
  input  logic [WIDTH-1:0] pmod_in
);

  localparam int unsigned H    = WIDTH / 2;
  localparam int unsigned IdxW = $clog2(2 * H);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StTurn, StDone} state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [H-1:0]      pat;
  logic [WIDTH-1:0]  expected;
  logic              settle_end;
  logic              last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      sync1_q <= pmod_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // Indices 0..H-1 walk a one, H..2H-1 walk a zero.
    if (idx_q < IdxW'(H)) begin
      pat = H'(1) << idx_q;
    end else begin
      pat = ~(H'(1) << (idx_q - IdxW'(H)));
    end
    expected   = {pat, pat};
    settle_end = (cnt_q == CntW'(SETTLE_CYCLES - 1));
    last_idx   = (idx_q == IdxW'(2 * H - 1));

    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mask_d   = mask_q;
    pmod_out = '0;
    pmod_oe  = '0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          phase_d = 1'b0;
          idx_d   = '0;
          err_d   = '0;
          mask_d  = '0;
        end
      end
      StDrive: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      StSettle: begin
        if (settle_end) state_d = StSample;
        else            cnt_d   = cnt_q + 1'b1;
      end
      StSample: begin
        if (sync2_q != expected) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          mask_d = mask_q | (sync2_q ^ expected);
        end
        if (last_idx) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = phase_q ? StDone : StTurn;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
      end
      StTurn: begin
        // All pins released before the other half starts driving.
        if (settle_end) begin
          state_d = StDrive;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StDrive || state_q == StSettle || state_q == StSample) begin
      if (phase_q) begin
        pmod_oe  = {{H{1'b1}}, {H{1'b0}}};
        pmod_out = {pat, {H{1'b0}}};
      end else begin
        pmod_oe  = {{H{1'b0}}, {H{1'b1}}};
        pmod_out = {{H{1'b0}}, pat};
      end
    end
  end

  assign busy      = (state_q == StDrive) || (state_q == StSettle) ||
                     (state_q == StSample) || (state_q == StTurn);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
